// File: rtl/mouse_pkg.sv
// mouse_pkg: PS/2 mouse packet states, status bit indices and delta bounding (MOUSE_WHEEL_EN adds B3)
package mouse_pkg;
`ifdef MOUSE_WHEEL_EN
  typedef enum logic [1:0] {B0, B1, B2, B3} state_t;
`else
  typedef enum logic [1:0] {B0, B1, B2} state_t;
`endif
  localparam int SYNC = 3;
  localparam int XS = 4;
  localparam int YS = 5;
  localparam int XO = 6;
  localparam int YO = 7;
  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;
  function automatic logic [7:0] bound(input logic [7:0] raw, input logic ovf, input logic neg, input logic en);
    return (en && ovf) ? (neg ? SAT_NEG : SAT_POS) : raw;
  endfunction
endpackage

// File: rtl/ps2_gap_timer.sv
// ps2_gap_timer: saturating inter-byte silence counter with expiry flag
module ps2_gap_timer #(
  parameter int GAP_CYC = 1_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(GAP_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(GAP_CYC);
  logic [W-1:0] cnt_q, cnt_d;
  // held at zero when idle or on a byte, otherwise count up and stick at the limit
  always_comb begin
    cnt_d = (clear || !enable) ? '0 : (cnt_q == LIMIT ? cnt_q : cnt_q + 1'b1);
  end
  // counter register
  always_ff @(posedge clk_sys) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
  assign expire = enable && cnt_q == LIMIT;
endmodule

// File: rtl/ps2_mouse_packer.sv
// ps2_mouse_packer: assembles PS/2 mouse bytes into Kempston ps2_mouse packets (MOUSE_WHEEL_EN: 4-byte wheel packets)
module ps2_mouse_packer
  import mouse_pkg::*;
#(
  parameter int GAP_CYC  = 1_000_000,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        byte_stb,
  input  logic [7:0]  byte_data,
  input  logic        byte_err,
  output logic [24:0] ps2_mouse,
  output logic [7:0]  pkt_cnt
`ifdef MOUSE_WHEEL_EN
  ,
  output logic [7:0]  wheel
`endif
);
  state_t state_q, state_d;
  logic [7:0] status_q, status_d, dx_q, dx_d, cnt_q, cnt_d, dy_raw;
  logic [24:0] mouse_q, mouse_d;
  logic expire, commit;
`ifdef MOUSE_WHEEL_EN
  localparam state_t LAST = B3;
  logic [7:0] dy_q, dy_d, wheel_q, wheel_d;
  assign dy_raw = dy_q;
  assign wheel = wheel_q;
`else
  localparam state_t LAST = B2;
  assign dy_raw = byte_data;
`endif
  ps2_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
    .clk_sys(clk_sys),
    .reset  (reset),
    .clear  (byte_stb),
    .enable (state_q != B0),
    .expire (expire)
  );
  // byte sequencing: error aborts, expiry re-evaluates the byte as a status byte
  always_comb begin
    state_d = state_q;
    status_d = status_q;
    dx_d = dx_q;
    commit = 1'b0;
`ifdef MOUSE_WHEEL_EN
    dy_d = dy_q;
`endif
    if (byte_err) state_d = B0;
    else if (expire || state_q == B0) begin
      state_d = (byte_stb && byte_data[SYNC]) ? B1 : B0;
      status_d = (byte_stb && byte_data[SYNC]) ? byte_data : status_q;
    end else if (byte_stb) begin
      commit = state_q == LAST;
      state_d = commit ? B0 : (state_q == B1 ? B2 : LAST);
      dx_d = state_q == B1 ? byte_data : dx_q;
`ifdef MOUSE_WHEEL_EN
      dy_d = state_q == B2 ? byte_data : dy_q;
`endif
    end
  end
  // packet commit: whole packet appears at once with the toggle flipped
  always_comb begin
    mouse_d = commit ? {~mouse_q[24], bound(dy_raw, status_q[YO], status_q[YS], SATURATE),
                        bound(dx_q, status_q[XO], status_q[XS], SATURATE), status_q} : mouse_q;
    cnt_d = commit ? cnt_q + 8'd1 : cnt_q;
`ifdef MOUSE_WHEEL_EN
    wheel_d = commit ? byte_data : wheel_q;
`endif
  end
  // state and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= B0;
      status_q <= '0;
      dx_q <= '0;
      mouse_q <= '0;
      cnt_q <= '0;
`ifdef MOUSE_WHEEL_EN
      dy_q <= '0;
      wheel_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      dx_q <= dx_d;
      mouse_q <= mouse_d;
      cnt_q <= cnt_d;
`ifdef MOUSE_WHEEL_EN
      dy_q <= dy_d;
      wheel_q <= wheel_d;
`endif
    end
  end
  assign ps2_mouse = mouse_q;
  assign pkt_cnt = cnt_q;
endmodule
